// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer.
// STORE_MERGE_EN enables same-address store merging.
package store_write_buffer_pkg;

    localparam int SWB_DEPTH_DEF = 4;
    localparam logic [1:0] SWB_ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } swb_entry_t;

    function automatic logic swb_aligned(input logic [31:0] addr);
        return (addr[1:0] & SWB_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Core-side and memory-bus-side signals of the store write buffer.
// master: the buffer itself; slave: core plus memory environment.
interface store_write_buffer_if #(
    parameter int CNT_W = 16
) ();
    logic             memwrite;
    logic [31:0]      dataaddr;
    logic [31:0]      writedata;
    logic             stall;
    logic             bus_valid;
    logic             bus_ready;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_data;
    logic             err_misaligned;
    logic [CNT_W-1:0] drained_cnt;

    modport master (
        input  memwrite, dataaddr, writedata, bus_ready,
        output stall, bus_valid, bus_addr, bus_data,
        output err_misaligned, drained_cnt
    );

    modport slave (
        output memwrite, dataaddr, writedata, bus_ready,
        input  stall, bus_valid, bus_addr, bus_data,
        input  err_misaligned, drained_cnt
    );
endinterface

// File: rtl/swb_fifo.sv
// Circular entry storage with head/tail pointers and occupancy count.
// STORE_MERGE_EN adds a data-overwrite port for the newest entry.
module swb_fifo
    import store_write_buffer_pkg::*;
#(
    parameter int  DEPTH = SWB_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  swb_entry_t       entry_i,
`ifdef STORE_MERGE_EN
    input  logic             merge_i,
    input  logic [31:0]      merge_data_i,
    output logic [31:0]      newest_addr_o,
`endif
    output swb_entry_t       head_o,
    output logic [OCC_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    swb_entry_t       mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] newest_idx;
    assign newest_idx    = tail_q - PTR_W'(1);
    assign newest_addr_o = mem_q[newest_idx].addr;
`endif

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) tail_d = tail_q + PTR_W'(1);
        if (pop_ok)  head_d = head_q + PTR_W'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset discards all buffered entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observable while count is nonzero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= entry_i;
        end
`ifdef STORE_MERGE_EN
        else if (merge_i) begin
            mem_q[newest_idx].data <= merge_data_i;
        end
`endif
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between core stores and the memory bus.
// Define STORE_MERGE_EN to merge stores hitting the newest entry.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = SWB_DEPTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    store_write_buffer_if.master  bus
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    swb_entry_t       head;
    swb_entry_t       new_entry;
    logic [OCC_W-1:0] count;
    logic             empty, full;
    logic             aligned, push, pop, merge;
    logic             err_q, err_d;
    logic [CNT_W-1:0] drained_q, drained_d;

    assign aligned   = swb_aligned(bus.dataaddr);
    assign pop       = !empty && bus.bus_ready;
    assign new_entry = '{addr: bus.dataaddr, data: bus.writedata};

`ifdef STORE_MERGE_EN
    logic [31:0] newest_addr;
    logic        merge_room;

    // A single entry may be leaving this cycle, so merging into it is unsafe.
    assign merge_room = (count > OCC_W'(1)) || (!empty && !pop);
    assign merge      = bus.memwrite && aligned && merge_room &&
                        (newest_addr == bus.dataaddr);
`else
    assign merge = 1'b0;
`endif

    assign push      = bus.memwrite && aligned && !full && !merge;
    assign bus.stall = bus.memwrite && aligned && full && !merge;

    swb_fifo #(
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .pop_i        (pop),
        .entry_i      (new_entry),
`ifdef STORE_MERGE_EN
        .merge_i      (merge),
        .merge_data_i (bus.writedata),
        .newest_addr_o(newest_addr),
`endif
        .head_o       (head),
        .count_o      (count),
        .empty_o      (empty),
        .full_o       (full)
    );

    assign bus.bus_valid      = !empty;
    assign bus.bus_addr       = empty ? 32'h0 : head.addr;
    assign bus.bus_data       = empty ? 32'h0 : head.data;
    assign bus.err_misaligned = err_q;
    assign bus.drained_cnt    = drained_q;

    // Error pulse for misaligned stores and drained-entry counter.
    always_comb begin
        err_d     = bus.memwrite && !aligned;
        drained_d = drained_q;
        if (pop) drained_d = drained_q + CNT_W'(1);
    end

    // Registered error flag and drain counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q     <= 1'b0;
            drained_q <= '0;
        end else begin
            err_q     <= err_d;
            drained_q <= drained_d;
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed table,
// hand sequences and random traffic against a queue-based model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    store_write_buffer_if #(.CNT_W(16)) bif ();

    store_write_buffer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_err;
    logic [15:0] m_drn;

    typedef struct {
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_err;
        logic [15:0] e_drn;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        bif.memwrite  = mw;
        bif.dataaddr  = a;
        bif.writedata = d;
        bif.bus_ready = rdy;
    endtask

    function automatic logic m_merge(input logic mw, input logic [31:0] a,
                                     input logic rdy);
`ifdef STORE_MERGE_EN
        if (!mw || a[1:0] != 2'b00 || mq.size() == 0) return 1'b0;
        if (mq[mq.size()-1].a != a) return 1'b0;
        if (mq.size() >= 2) return 1'b1;
        return !rdy;
`else
        if (mw && rdy && a == 32'h1) return 1'b0;
        return 1'b0;
`endif
    endfunction

    task automatic m_check(input logic mw, input logic [31:0] a,
                           input logic rdy);
        logic        al, mg, v;
        logic [31:0] ea, ed;
        al = (a[1:0] == 2'b00);
        mg = m_merge(mw, a, rdy);
        v  = (mq.size() != 0);
        ea = v ? mq[0].a : 32'h0;
        ed = v ? mq[0].d : 32'h0;
        chk("m_stall", 32'(bif.stall),
            32'(mw && al && mq.size() == DEPTH && !mg));
        chk("m_valid", 32'(bif.bus_valid), 32'(v));
        chk("m_addr", bif.bus_addr, ea);
        chk("m_data", bif.bus_data, ed);
        chk("m_err", 32'(bif.err_misaligned), 32'(m_err));
        chk("m_drn", 32'(bif.drained_cnt), 32'(m_drn));
    endtask

    task automatic m_adv(input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        logic al, mg, pop, psh;
        al  = (a[1:0] == 2'b00);
        mg  = m_merge(mw, a, rdy);
        pop = (mq.size() != 0) && rdy;
        psh = mw && al && (mq.size() < DEPTH) && !mg;
        if (pop) begin
            void'(mq.pop_front());
            m_drn = m_drn + 16'd1;
        end
        if (mg) mq[mq.size()-1].d = d;
        if (psh) mq.push_back('{a: a, d: d});
        m_err = mw && !al;
    endtask

    task automatic step(input logic mw, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
        drive(mw, a, d, rdy);
        #1;
        m_check(mw, a, rdy);
        m_adv(mw, a, d, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
        mq.delete();
        m_err = 1'b0;
        m_drn = 16'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic mw, input logic [31:0] a, input logic [31:0] d,
        input logic rdy, input logic st, input logic v,
        input logic [31:0] ea, input logic [31:0] ed,
        input logic er, input logic [15:0] dn);
        vec_t r;
        r = '{mw, a, d, rdy, st, v, ea, ed, er, dn};
        return r;
    endfunction

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        mq.delete();
        m_err = 1'b0;
        m_drn = 16'd0;
        #2;
        chk("rst_valid", 32'(bif.bus_valid), 32'h0);
        chk("rst_stall", 32'(bif.stall), 32'h0);
        chk("rst_err", 32'(bif.err_misaligned), 32'h0);
        chk("rst_drn", 32'(bif.drained_cnt), 32'h0);
        chk("rst_addr", bif.bus_addr, 32'h0);
        do_reset();

        tbl.push_back(mk(1, 84, 32'hFFFFFFFB, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 84, 32'hFFFFFFFB, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'hA0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4, 32'hA1, 0, 0, 1, 0, 32'hA0, 0, 1));
        tbl.push_back(mk(1, 8, 32'hA2, 0, 0, 1, 0, 32'hA0, 0, 1));
        tbl.push_back(mk(1, 12, 32'hA3, 0, 0, 1, 0, 32'hA0, 0, 1));
        tbl.push_back(mk(1, 16, 32'hA4, 0, 1, 1, 0, 32'hA0, 0, 1));
        tbl.push_back(mk(1, 16, 32'hA4, 0, 1, 1, 0, 32'hA0, 0, 1));
        tbl.push_back(mk(1, 16, 32'hA4, 1, 1, 1, 0, 32'hA0, 0, 1));
        tbl.push_back(mk(1, 16, 32'hA4, 0, 0, 1, 4, 32'hA1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4, 32'hA1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 8, 32'hA2, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 12, 32'hA3, 0, 4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16, 32'hA4, 0, 5));
        tbl.push_back(mk(1, 86, 7, 1, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 6));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 6));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rdy);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bif.stall),
                32'(tbl[i].e_stall));
            chk($sformatf("v%0d_valid", i), 32'(bif.bus_valid),
                32'(tbl[i].e_valid));
            chk($sformatf("v%0d_addr", i), bif.bus_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_data", i), bif.bus_data, tbl[i].e_data);
            chk($sformatf("v%0d_err", i), 32'(bif.err_misaligned),
                32'(tbl[i].e_err));
            chk($sformatf("v%0d_drn", i), 32'(bif.drained_cnt),
                32'(tbl[i].e_drn));
            m_adv(tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rdy);
            @(posedge clk);
            @(negedge clk);
        end

        do_reset();
        step(1, 32'h200, 32'h11, 0);
        step(1, 32'h204, 32'h22, 0);
        step(1, 32'h208, 32'h33, 0);
        step(0, 0, 0, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(bif.bus_valid), 32'h0);
        chk("midrst_drn", 32'(bif.drained_cnt), 32'h0);
        chk("midrst_addr", bif.bus_addr, 32'h0);
        mq.delete();
        m_err = 1'b0;
        m_drn = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("postrst_valid", 32'(bif.bus_valid), 32'h0);
        end

        do_reset();
        step(1, 100, 1, 0);
        step(1, 100, 2, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
`ifdef STORE_MERGE_EN
        chk("merge_data0", bif.bus_data, 32'd2);
        step(0, 0, 0, 1);
        chk("merge_empty", 32'(bif.bus_valid), 32'h0);
`else
        chk("nomerge_data0", bif.bus_data, 32'd1);
        step(0, 0, 0, 1);
        chk("nomerge_data1", bif.bus_data, 32'd2);
        step(0, 0, 0, 1);
        chk("nomerge_empty", 32'(bif.bus_valid), 32'h0);
`endif

        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [31:0] addrs [8];
            logic [31:0] ra;
            addrs = '{32'h0, 32'h4, 32'h8, 32'hC,
                      32'd100, 32'd100, 32'd86, 32'd103};
            ra = addrs[$urandom_range(0, 7)];
            step(($urandom_range(0, 9) < 7), ra, $urandom,
                 ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 16, width of the drained-store counter.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port memwrite  input  1  store request from the core.
REQ-006 Port dataaddr  input  32  store byte address from the core.
REQ-007 Port writedata  input  32  store data from the core.
REQ-008 Port stall  output  1  core SHALL hold the current instruction while high.
REQ-009 Port bus_valid  output  1  head entry presented to the memory bus.
REQ-010 Port bus_ready  input  1  memory bus accepts the head entry.
REQ-011 Port bus_addr  output  32  head entry address.
REQ-012 Port bus_data  output  32  head entry data.
REQ-013 Port err_misaligned  output  1  one-cycle pulse for each dropped misaligned store.
REQ-014 Port drained_cnt  output  CNT_W  count of entries accepted by the bus.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH {addr,data} entries with head/tail pointers and an occupancy count 0..DEPTH.
REQ-016 Push SHALL occur when memwrite=1, dataaddr[1:0]=00, and count<DEPTH.
REQ-017 Pop SHALL occur when bus_valid=1 and bus_ready=1.
REQ-018 Simultaneous push and pop SHALL leave count unchanged.
REQ-019 Push SHALL be refused when count=DEPTH, even if a pop occurs in the same cycle.
REQ-020 stall SHALL be combinational: memwrite AND count=DEPTH AND dataaddr[1:0]=00.
REQ-021 bus_valid SHALL equal (count!=0); bus_addr and bus_data SHALL be driven from the head entry.
REQ-022 A store pushed at edge N SHALL appear on the bus during cycle N+1 when the FIFO was empty (latency 1 cycle).
REQ-023 While bus_valid=1 and bus_ready=0, bus_addr and bus_data SHALL remain stable.
REQ-024 Entries SHALL drain in push order.
REQ-025 A store with dataaddr[1:0]!=00 SHALL be dropped without a push or stall.
REQ-026 For such a dropped store, err_misaligned SHALL be registered high for the following cycle only.
REQ-027 drained_cnt SHALL increment by 1 on each pop and wrap modulo 2^CNT_W.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 bus_ready while count=0 SHALL be ignored.

Reset
REQ-030 reset=1 SHALL immediately clear:
  - count, head and tail to 0;
  - bus_valid and err_misaligned to 0;
  - drained_cnt to 0.
REQ-031 Stores buffered when reset asserts SHALL be discarded and never presented.
REQ-032 bus_addr and bus_data SHALL read 0 while count=0.

Configuration
REQ-033 With STORE_MERGE_EN defined, a store SHALL merge instead of push when all of the following hold:
  - it is aligned;
  - its address equals the newest entry's address;
  - count>=2, or count=1 and no pop occurs this cycle.
REQ-034 A merge SHALL overwrite that entry's data and leave count unchanged.
REQ-035 A merge SHALL be allowed even when count=DEPTH, and stall SHALL then be 0.
REQ-036 Without STORE_MERGE_EN, every aligned store SHALL follow REQ-016..REQ-020 and no merge logic SHALL exist.

Structure
REQ-037 A shared package SHALL hold the entry typedef {addr[31:0], data[31:0]}, the default DEPTH and the alignment-mask constant.
REQ-038 One sub-module, swb_fifo (storage, pointers, count), SHALL be instantiated by store_write_buffer, which owns stall, error, merge and counter logic.

Verification
REQ-039 Reset, then memwrite with addr=84, data=-5, bus_ready=1 -> bus_valid=1 next cycle with bus_addr=84, bus_data=0xFFFFFFFB; drained_cnt=1 one cycle later.
REQ-040 bus_ready=0, five stores to addresses 0,4,8,12,16 -> the fifth cycle has stall=1 and count stays 4; the address-16 store is accepted only after bus_ready rises and a slot frees.
REQ-041 Full FIFO, then push and bus_ready=1 in the same cycle -> push refused, stall=1, count falls to 3, and the head advances to address 4.
REQ-042 Store to addr=86 -> no push, stall=0, err_misaligned=1 for exactly one cycle.
REQ-043 reset asserted mid-drain with 3 entries buffered -> bus_valid=0 immediately; drained_cnt=0; the old entries never reappear.
REQ-044 With STORE_MERGE_EN, bus_ready=0, stores {100,1} then {100,2} -> count=1 and bus_data=2; without the macro -> count=2 and data drains as 1 then 2.
